// File: rtl/aes_inv_cipher_iter.sv
// Iterative AES inverse cipher: one round per clock, round keys fetched by index NR..0.
// Optional macro AES_INV_ABORT_EN adds an abort_i port that cancels an in-flight block.
module aes_inv_cipher_iter #(
    parameter int NR = 10
) (
    input  logic         clk_i,
    input  logic         rst_i,
`ifdef AES_INV_ABORT_EN
    input  logic         abort_i,
`endif
    input  logic         start_i,
    input  logic [127:0] ciphertext_i,
    output logic [3:0]   rk_idx_o,
    input  logic [127:0] round_key_i,
    output logic         busy_o,
    output logic         done_o,
    output logic [127:0] plaintext_o
);

    generate
        if (!(NR == 10 || NR == 12 || NR == 14)) begin : g_nr_check
            $error("aes_inv_cipher_iter: NR must be 10, 12 or 14");
        end
    endgenerate

    localparam logic [3:0] NR_IDX = 4'(NR);

    // IDLE: waiting for start | ROUND: full inverse rounds | FINAL: last round, no InvMixColumns
    typedef enum logic [1:0] {IDLE, ROUND, FINAL} state_e;

    state_e         fsm_q, fsm_d;
    logic [127:0]   blk_q, blk_d;
    logic [127:0]   pt_q, pt_d;
    logic [3:0]     rk_q, rk_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic [127:0]   sr_sb;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] t;
        p = 8'h00;
        t = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ t;
            t = xtime(t);
        end
        return p;
    endfunction

    // Field inverse as a^254; yields 0 for 0 without a special case.
    function automatic logic [7:0] ginv(input logic [7:0] a);
        logic [7:0] a2, a3, a12, a15, a240;
        a2   = gmul(a, a);
        a3   = gmul(a2, a);
        a12  = gmul(gmul(a3, a3), gmul(a3, a3));
        a15  = gmul(a12, a3);
        a240 = gmul(a15, a15);
        a240 = gmul(a240, a240);
        a240 = gmul(a240, a240);
        a240 = gmul(a240, a240);
        return gmul(gmul(a240, a12), a2);
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        logic [7:0] a;
        a = {b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]} ^ 8'h05;
        return ginv(a);
    endfunction

    function automatic logic [127:0] inv_shift_sub(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127-8*(r+4*c) -: 8] = inv_sbox(s[127-8*(r+4*((c-r+4)%4)) -: 8]);
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] inv_mix(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            o[127-32*c -: 32] = {
                gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09),
                gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d),
                gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b),
                gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e)};
        end
        return o;
    endfunction

    assign sr_sb = inv_shift_sub(blk_q);

    always_comb begin
        fsm_d  = fsm_q;
        blk_d  = blk_q;
        pt_d   = pt_q;
        rk_d   = rk_q;
        busy_d = busy_q;
        done_d = 1'b0;
        case (fsm_q)
            IDLE: begin
                if (start_i) begin
                    blk_d  = ciphertext_i ^ round_key_i;
                    rk_d   = NR_IDX - 4'd1;
                    busy_d = 1'b1;
                    fsm_d  = ROUND;
                end
            end
            ROUND: begin
                blk_d = inv_mix(sr_sb ^ round_key_i);
                rk_d  = rk_q - 4'd1;
                if (rk_q == 4'd1) fsm_d = FINAL;
            end
            FINAL: begin
                pt_d   = sr_sb ^ round_key_i;
                done_d = 1'b1;
                busy_d = 1'b0;
                rk_d   = NR_IDX;
                fsm_d  = IDLE;
            end
            default: fsm_d = IDLE;
        endcase
`ifdef AES_INV_ABORT_EN
        if (abort_i && fsm_q != IDLE) begin
            fsm_d  = IDLE;
            blk_d  = blk_q;
            pt_d   = pt_q;
            rk_d   = NR_IDX;
            busy_d = 1'b0;
            done_d = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fsm_q  <= IDLE;
            blk_q  <= '0;
            pt_q   <= '0;
            rk_q   <= NR_IDX;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            fsm_q  <= fsm_d;
            blk_q  <= blk_d;
            pt_q   <= pt_d;
            rk_q   <= rk_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    assign rk_idx_o    = rk_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign plaintext_o = pt_q;

endmodule
